pipeline_id_regread: RTL and testbench

// - Read end of the WB register write port: 32x64 integer register file plus a per-register

---
 rtl/pipeline_defs.sv | 10 +
 rtl/pipeline_scoreboard.sv | 65 ++++++
 rtl/pipeline_id_regread.sv | 98 +++++++++
 tb/tb_pipeline_id_regread.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared sizing constants for the ID-stage register read block and its scoreboard.
package pipeline_defs;
  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int PEND_W   = 2;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/pipeline_scoreboard.sv
// Per-register count of in-flight writers: bumped on issue, dropped on writeback or squash.
module pipeline_scoreboard
  import pipeline_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_valid,
  input  logic [REG_AW-1:0] inc_rd,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              kill_valid,
  input  logic [REG_AW-1:0] kill_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic [PEND_W-1:0] pend1,
  output logic [PEND_W-1:0] pend2,
  output logic [PEND_W-1:0] pend_rd
);

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic              underflow;
  int                sum;

  // All three events may hit the same register; the net sum is applied and clamped.
  always_comb begin
    underflow = 1'b0;
    sum       = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      sum = int'(pend_q[r]);
      if (r != 0) begin
        if (inc_valid  && inc_rd  == REG_AW'(r)) sum = sum + 1;
        if (dec_valid  && dec_rd  == REG_AW'(r)) sum = sum - 1;
        if (kill_valid && kill_rd == REG_AW'(r)) sum = sum - 1;
      end
      if (sum < 0) begin
        pend_d[r] = '0;
        underflow = 1'b1;
      end else if (sum > int'(PEND_MAX)) begin
        pend_d[r] = PEND_MAX;
      end else begin
        pend_d[r] = PEND_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

  // A retirement or squash with no matching issued writer means the pipeline lost track.
  always_ff @(posedge clk) begin
    if (reset) assert (!underflow);
  end

  assign pend1   = pend_q[rs1];
  assign pend2   = pend_q[rs2];
  assign pend_rd = pend_q[rd];

endmodule

// File: rtl/pipeline_id_regread.sv
// ID-stage register file read with WB bypass, pending-write interlock and ID->EX operand register.
module pipeline_id_regread
  import pipeline_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_WB,
  input  logic [REG_AW-1:0] rd_WB,
  input  logic [XLEN-1:0]   write_data_WB,
  input  logic              issue_valid_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              reg_write_ID,
  input  logic              kill_valid,
  input  logic [REG_AW-1:0] kill_rd,
  output logic              stall_ID,
  output logic              valid_EX,
  output logic [XLEN-1:0]   rs1_data_EX,
  output logic [XLEN-1:0]   rs2_data_EX
);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [XLEN-1:0]   regs_d [NUM_REGS];
  logic              valid_ex_q, valid_ex_d;
  logic [XLEN-1:0]   rs1_data_ex_q, rs1_data_ex_d;
  logic [XLEN-1:0]   rs2_data_ex_q, rs2_data_ex_d;
  logic [PEND_W-1:0] pend1, pend2, pend_rd;
  logic              wb_rs1, wb_rs2, hazard1, hazard2, saturated, accept;
  logic [XLEN-1:0]   rs1_val, rs2_val;

  pipeline_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .inc_valid  (accept && reg_write_ID),
    .inc_rd     (rd_ID),
    .dec_valid  (reg_write_WB),
    .dec_rd     (rd_WB),
    .kill_valid (kill_valid),
    .kill_rd    (kill_rd),
    .rs1        (rs1_ID),
    .rs2        (rs2_ID),
    .rd         (rd_ID),
    .pend1      (pend1),
    .pend2      (pend2),
    .pend_rd    (pend_rd)
  );

  assign wb_rs1 = reg_write_WB && rd_WB == rs1_ID && rs1_ID != REG_ZERO;
  assign wb_rs2 = reg_write_WB && rd_WB == rs2_ID && rs2_ID != REG_ZERO;

  // A lone pending writer that is retiring this cycle is covered by the bypass.
  always_comb begin
    hazard1   = rs1_used_ID && rs1_ID != REG_ZERO &&
                !(pend1 == '0 || (pend1 == PEND_W'(1) && wb_rs1));
    hazard2   = rs2_used_ID && rs2_ID != REG_ZERO &&
                !(pend2 == '0 || (pend2 == PEND_W'(1) && wb_rs2));
    saturated = reg_write_ID && rd_ID != REG_ZERO && pend_rd == PEND_MAX;
    stall_ID  = issue_valid_ID && (hazard1 || hazard2 || saturated);
    accept    = issue_valid_ID && !stall_ID;
  end

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_used_ID && rs1_ID != REG_ZERO) rs1_val = wb_rs1 ? write_data_WB : regs_q[rs1_ID];
    if (rs2_used_ID && rs2_ID != REG_ZERO) rs2_val = wb_rs2 ? write_data_WB : regs_q[rs2_ID];
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (reg_write_WB && rd_WB != REG_ZERO) regs_d[rd_WB] = write_data_WB;
    valid_ex_d    = accept;
    rs1_data_ex_d = accept ? rs1_val : rs1_data_ex_q;
    rs2_data_ex_d = accept ? rs2_val : rs2_data_ex_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      valid_ex_q    <= 1'b0;
      rs1_data_ex_q <= '0;
      rs2_data_ex_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
      valid_ex_q    <= valid_ex_d;
      rs1_data_ex_q <= rs1_data_ex_d;
      rs2_data_ex_q <= rs2_data_ex_d;
    end
  end

  assign valid_EX    = valid_ex_q;
  assign rs1_data_EX = rs1_data_ex_q;
  assign rs2_data_EX = rs2_data_ex_q;

endmodule

// File: tb/tb_pipeline_id_regread.sv
// Directed and randomized check of pipeline_id_regread against a register/pending-count model.
module tb_pipeline_id_regread;

  localparam int PEND_LIMIT = 3;

  logic        clk;
  logic        reset;
  logic        reg_write_WB;
  logic [4:0]  rd_WB;
  logic [63:0] write_data_WB;
  logic        issue_valid_ID;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID, kill_rd;
  logic        rs1_used_ID, rs2_used_ID, reg_write_ID, kill_valid;
  logic        stall_ID, valid_EX;
  logic [63:0] rs1_data_EX, rs2_data_EX;

  logic [63:0] m_regs [32];
  int          m_pend [32];
  logic        exp_valid;
  logic [63:0] exp_d1, exp_d2;
  int          n_checks = 0;
  int          n_fail   = 0;

  pipeline_id_regread dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write_WB   (reg_write_WB),
    .rd_WB          (rd_WB),
    .write_data_WB  (write_data_WB),
    .issue_valid_ID (issue_valid_ID),
    .rs1_ID         (rs1_ID),
    .rs2_ID         (rs2_ID),
    .rs1_used_ID    (rs1_used_ID),
    .rs2_used_ID    (rs2_used_ID),
    .rd_ID          (rd_ID),
    .reg_write_ID   (reg_write_ID),
    .kill_valid     (kill_valid),
    .kill_rd        (kill_rd),
    .stall_ID       (stall_ID),
    .valid_EX       (valid_EX),
    .rs1_data_EX    (rs1_data_EX),
    .rs2_data_EX    (rs2_data_EX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 0;
    end
    exp_valid = 1'b0;
    exp_d1    = '0;
    exp_d2    = '0;
  endtask

  function automatic logic wb_to(input int r);
    return reg_write_WB && int'(rd_WB) == r && r != 0;
  endfunction

  function automatic logic [63:0] m_read(input int r, input logic used);
    if (!used || r == 0) return '0;
    if (wb_to(r)) return write_data_WB;
    return m_regs[r];
  endfunction

  function automatic logic m_hazard(input int r, input logic used);
    if (!used || r == 0) return 1'b0;
    if (m_pend[r] == 0) return 1'b0;
    if (m_pend[r] == 1 && wb_to(r)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_idle();
    issue_valid_ID = 0; rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    rd_ID = 0; reg_write_ID = 0; reg_write_WB = 0; rd_WB = 0; write_data_WB = '0;
    kill_valid = 0; kill_rd = 0;
  endtask

  task automatic apply_stimulus(input int rs1, input logic u1, input int rs2, input logic u2,
                                input int rd, input logic w);
    issue_valid_ID = 1'b1;
    rs1_ID = 5'(rs1); rs1_used_ID = u1;
    rs2_ID = 5'(rs2); rs2_used_ID = u2;
    rd_ID  = 5'(rd);  reg_write_ID = w;
  endtask

  task automatic set_wb(input int rd, input logic [63:0] data);
    reg_write_WB = 1'b1; rd_WB = 5'(rd); write_data_WB = data;
  endtask

  task automatic set_kill(input int rd);
    kill_valid = 1'b1; kill_rd = 5'(rd);
  endtask

  // Checks the combinational stall now, advances one clock, then checks the EX register.
  task automatic step(input string tag);
    logic e_stall, e_acc;
    #1;
    e_stall = issue_valid_ID && (m_hazard(int'(rs1_ID), rs1_used_ID) ||
                                 m_hazard(int'(rs2_ID), rs2_used_ID) ||
                                 (reg_write_ID && rd_ID != 0 && m_pend[rd_ID] == PEND_LIMIT));
    check_output({tag, " stall"}, 64'(stall_ID), 64'(e_stall));
    e_acc = issue_valid_ID && !e_stall;
    exp_valid = e_acc;
    if (e_acc) begin
      exp_d1 = m_read(int'(rs1_ID), rs1_used_ID);
      exp_d2 = m_read(int'(rs2_ID), rs2_used_ID);
      if (reg_write_ID && rd_ID != 0) m_pend[rd_ID] = m_pend[rd_ID] + 1;
    end
    if (wb_to(int'(rd_WB))) begin
      m_regs[rd_WB] = write_data_WB;
      m_pend[rd_WB] = (m_pend[rd_WB] > 0) ? m_pend[rd_WB] - 1 : 0;
    end
    if (kill_valid && kill_rd != 0)
      m_pend[kill_rd] = (m_pend[kill_rd] > 0) ? m_pend[kill_rd] - 1 : 0;
    @(posedge clk);
    #1;
    check_output({tag, " valid_EX"}, 64'(valid_EX), 64'(exp_valid));
    check_output({tag, " rs1_data_EX"}, rs1_data_EX, exp_d1);
    check_output({tag, " rs2_data_EX"}, rs2_data_EX, exp_d2);
  endtask

  initial begin
    int cand[$];
    int pick;

    set_idle();
    model_reset();
    reset = 1'b0;
    #12;
    check_output("reset stall", 64'(stall_ID), 64'd0);
    check_output("reset valid", 64'(valid_EX), 64'd0);
    check_output("reset rs1", rs1_data_EX, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 1; r < 32; r++) begin
      set_idle(); apply_stimulus(r, 1, r, 1, 0, 0); step("reset read");
    end

    // Write then read, and x0 ignores writes.
    set_idle(); apply_stimulus(0, 0, 0, 0, 5, 1); step("wr5 issue");
    set_idle(); set_wb(5, 64'hDEAD_BEEF); step("wr5 wb");
    set_idle(); apply_stimulus(5, 1, 0, 1, 0, 0); step("rd5");
    check_output("rd5 value", rs1_data_EX, 64'hDEAD_BEEF);
    set_idle(); set_wb(0, 64'h1234); apply_stimulus(0, 1, 0, 1, 0, 0); step("x0");
    check_output("x0 value", rs1_data_EX, 64'd0);

    // RAW interlock released by the matching writeback.
    set_idle(); apply_stimulus(0, 0, 0, 0, 7, 1); step("raw writer");
    set_idle(); apply_stimulus(0, 0, 7, 1, 0, 0); step("raw stall a");
    set_idle(); apply_stimulus(0, 0, 7, 1, 0, 0); step("raw stall b");
    set_idle(); apply_stimulus(0, 0, 7, 1, 0, 0); set_wb(7, 64'd42); step("raw release");
    check_output("raw value", rs2_data_EX, 64'd42);

    // Saturation of the x3 counter.
    for (int i = 0; i < 3; i++) begin
      set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); step("sat fill");
    end
    set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); step("sat stall");
    set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); set_wb(3, 64'h33); step("sat wb stall");
    set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); set_wb(3, 64'h34); step("sat net zero");
    set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); step("sat refill");
    set_idle(); apply_stimulus(0, 0, 0, 0, 3, 1); step("sat stall again");
    for (int i = 0; i < 3; i++) begin
      set_idle(); set_wb(3, 64'(100 + i)); step("sat drain");
    end

    // Kill returns the old register value.
    set_idle(); apply_stimulus(0, 0, 0, 0, 9, 1); step("kill w1");
    set_idle(); set_wb(9, 64'h55); step("kill wb");
    set_idle(); apply_stimulus(0, 0, 0, 0, 9, 1); step("kill w2");
    set_idle(); set_kill(9); step("kill");
    set_idle(); apply_stimulus(9, 1, 0, 0, 0, 0); step("kill read");
    check_output("kill value", rs1_data_EX, 64'h55);

    // Randomized traffic that never retires or squashes a writer that was not issued.
    for (int c = 0; c < 400; c++) begin
      set_idle();
      if ($urandom_range(0, 99) < 75)
        apply_stimulus($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                       $urandom_range(0, 7), 1'($urandom));
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 99) < 55)
        set_wb(cand[$urandom_range(0, cand.size() - 1)], {$urandom, $urandom});
      else if ($urandom_range(0, 99) < 10)
        set_wb(0, {$urandom, $urandom});
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r] - int'(wb_to(r)) > 0) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 99) < 15) begin
        pick = cand[$urandom_range(0, cand.size() - 1)];
        set_kill(pick);
      end
      step("random");
    end

    // Asynchronous reset while stalled.
    set_idle(); apply_stimulus(0, 0, 0, 0, 11, 1); step("ar writer");
    set_idle(); apply_stimulus(11, 1, 0, 0, 0, 0);
    #1;
    check_output("ar stalled", 64'(stall_ID), 64'd1);
    reset = 1'b0;
    #1;
    check_output("ar stall", 64'(stall_ID), 64'd0);
    check_output("ar valid", 64'(valid_EX), 64'd0);
    check_output("ar rs1", rs1_data_EX, 64'd0);
    check_output("ar rs2", rs2_data_EX, 64'd0);
    model_reset();
    set_idle();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 1; r < 32; r++) begin
      set_idle(); apply_stimulus(r, 1, r, 1, 0, 0); step("post reset read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
